// File: rtl/fifo_read_scheduler.sv
// Round-robin read scheduler for per-input-port FIFOs: grants one non-empty FIFO
// per burst, issues read strobes, and tags returned words with their source port.
module fifo_read_scheduler #(
    parameter int nPorts   = 4,
    parameter int width    = 8,
    parameter int maxBurst = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [nPorts-1:0]         empty,
    input  logic [nPorts*width-1:0]   readData,
    output logic [nPorts-1:0]         read,
    output logic [width-1:0]          outData,
    output logic [$clog2(nPorts)-1:0] outPort,
    output logic                      outValid,
    input  logic                      outReady
);

    localparam int PW = $clog2(nPorts);
    localparam int BW = $clog2(maxBurst + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state;
    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          grant;
    logic [PW-1:0]          next_grant;
    logic [PW-1:0]          fly_port;
    logic [BW-1:0]          burst_cnt;
    logic                   in_flight;
    logic                   any_ready;
    logic                   pop;
    logic                   push;
    logic                   credit_ok;
    logic                   do_read;
    logic [1:0]             count;
    logic [1:0]             occ;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [width-1:0]       fly_data;
    logic [PW+width-1:0]    buf_mem [2];

    // First non-empty FIFO at or after rr_ptr, scanning cyclically.
    always_comb begin
        int unsigned idx;
        next_grant = '0;
        any_ready  = 1'b0;
        idx        = 0;
        for (int unsigned k = 0; k < nPorts; k++) begin
            idx = (32'(rr_ptr) + k) % nPorts;
            if (!any_ready && !empty[idx]) begin
                next_grant = PW'(idx);
                any_ready  = 1'b1;
            end
        end
    end

    // A read is allowed only if its word is guaranteed a buffer slot on return.
    always_comb begin
        pop       = outValid & outReady;
        push      = in_flight;
        occ       = count + {1'b0, in_flight};
        credit_ok = (occ - {1'b0, pop}) < 2'd2;
        do_read   = (state == GRANT) && !empty[grant] && credit_ok;
        read      = do_read ? (nPorts'(1) << grant) : '0;
        fly_data  = readData[32'(fly_port) * width +: width];
        outValid  = (count != 2'd0);
        outData   = buf_mem[rd_ptr][width-1:0];
        outPort   = buf_mem[rd_ptr][PW+width-1:width];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            burst_cnt  <= '0;
            in_flight  <= 1'b0;
            fly_port   <= '0;
            count      <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else begin
            assert (!(push && !pop && count == 2'd2));

            in_flight <= do_read;
            if (do_read) fly_port <= grant;

            if (push) begin
                buf_mem[wr_ptr] <= {fly_port, fly_data};
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            if (push && !pop)      count <= count + 2'd1;
            else if (pop && !push) count <= count - 2'd1;

            case (state)
                IDLE: begin
                    if (any_ready) begin
                        grant     <= next_grant;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (do_read) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        if (burst_cnt == BW'(maxBurst - 1)) begin
                            state  <= IDLE;
                            rr_ptr <= (grant == PW'(nPorts - 1)) ? '0 : grant + 1'b1;
                        end
                    end else if (empty[grant]) begin
                        state  <= IDLE;
                        rr_ptr <= (grant == PW'(nPorts - 1)) ? '0 : grant + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
